// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-line instruction cache sitting between the
// fetch unit and the memory controller's instruction port.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   rdy                            global ready; low freezes every register
//   fetch_valid, fetch_pc          fetch request (accepted only while fetch_ready)
//   fetch_ready                    high in IDLE (outside reset)
//   clear                          redirect: drop the current/pending response
//   ins_valid, ins_out, ins_pc     one-cycle instruction response
//   mc_req, mc_addr                one-cycle word read request to the MC
//   mc_ins, mc_ins_rdy             word returned by the MC
//
// Hits answer one cycle after the request. A miss pulses mc_req once; the MC
// queues it, so there is never a retry. A redirect during a miss moves to DRAIN:
// the returning word still fills the line (it is correct for mc_addr) but is not
// forwarded to fetch.
module icache #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  output logic        fetch_ready,
  input  logic        clear,
  output logic        ins_valid,
  output logic [31:0] ins_out,
  output logic [31:0] ins_pc,
  output logic        mc_req,
  output logic [31:0] mc_addr,
  input  logic [31:0] mc_ins,
  input  logic        mc_ins_rdy
);
  localparam int NUM_LINES = 1 << INDEX_BITS;
  localparam int TAG_BITS  = 30 - INDEX_BITS;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

  state_t state_q, state_d;

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_BITS-1:0]  tag_mem  [NUM_LINES];
  logic [31:0]          data_mem [NUM_LINES];

  logic [INDEX_BITS-1:0] fidx, midx;
  logic [TAG_BITS-1:0]   ftag, mtag;
  logic                  hit;

  // per-cycle strobes decoded from the FSM
  logic hit_en, miss_en, fill_en, fwd_en;

  assign fidx = fetch_pc[INDEX_BITS+1:2];
  assign ftag = fetch_pc[31:INDEX_BITS+2];
  assign midx = mc_addr[INDEX_BITS+1:2];
  assign mtag = mc_addr[31:INDEX_BITS+2];
  assign hit  = valid_q[fidx] && (tag_mem[fidx] == ftag);

  assign fetch_ready = (state_q == S_IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst)      state_q <= S_IDLE;
    else if (rdy) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    hit_en  = 1'b0;
    miss_en = 1'b0;
    fill_en = 1'b0;
    fwd_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // clear wins over a same-cycle request, hit or miss
        if (fetch_valid && !clear) begin
          if (hit) hit_en = 1'b1;
          else begin
            miss_en = 1'b1;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (mc_ins_rdy) begin
          fill_en = 1'b1;
          fwd_en  = !clear;
          state_d = S_IDLE;
        end else if (clear) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (mc_ins_rdy) begin
          fill_en = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      ins_valid <= 1'b0;
      ins_out   <= '0;
      ins_pc    <= '0;
      mc_req    <= 1'b0;
      mc_addr   <= '0;
    end else if (rdy) begin
      ins_valid <= hit_en | fwd_en;
      mc_req    <= miss_en;
      if (hit_en) begin
        ins_out <= data_mem[fidx];
        ins_pc  <= fetch_pc;
      end
      if (fwd_en) begin
        ins_out <= mc_ins;
        ins_pc  <= mc_addr;
      end
      if (miss_en) mc_addr <= {fetch_pc[31:2], 2'b00};
      if (fill_en) valid_q[midx] <= 1'b1;
    end
  end

  // tag/data arrays carry no reset; valid_q alone qualifies them
  always_ff @(posedge clk) begin
    if (!rst && rdy && fill_en) begin
      tag_mem[midx]  <= mtag;
      data_mem[midx] <= mc_ins;
    end
  end

endmodule
